mitll_ndro_bank: RTL and testbench
==================================

// Module: mitll_ndro_bank
// PURPOSE
// - Clocked behavioural model of CHANNELS independent RSFQ NDRO cells (set / reset / non-destructive read).
// - Adds a configurable settling window, violation flags and an optional destructive (DRO) read mode.
// - Used in system-level benches in place of per-cell mitll_ndro instances.
// - Pulses are one-cycle-high strobes sampled on the rising clock edge.
// PARAMETERS
// - CHANNELS    4  number of independent cells (>=1)
// - SETTLE_CYC  2  cycles after set/reset before the new state is readable (0..15)
// - DESTRUCTIVE 0  1: a read of a stored 1 also clears the cell (DRO behaviour)
// - CNT_W       8  width of violation counter (macro only)
// PORTS
// - clk       in   1         rising-edge clock
// - rst_n     in   1         asynchronous active-low reset
// - set       in   CHANNELS  per-channel set pulse
// - reset     in   CHANNELS  per-channel reset pulse
// - rd        in   CHANNELS  per-channel read pulse (the NDRO "clk" input)
// - out       out  CHANNELS  per-channel readout pulse, registered
// - state     out  CHANNELS  per-channel readable stored value (level)
// - viol      out  CHANNELS  per-channel one-cycle violation pulse, registered
// - viol_cnt  out  CNT_W     saturating violation count (NDRO_BANK_VIOL_CNT_EN only)
// BEHAVIOUR
// - Reset (rst_n=0, async): all cells in S0; out, state, viol = 0; settle counters = 0; viol_cnt = 0.
// - Per-channel FSM: S0 (holds 0), S1 (holds 1), PEND1 (settling toward 1), PEND0 (settling toward 0).
// - set in S0 -> PEND1; counter loads SETTLE_CYC-1; PEND1 -> S1 when counter reaches 0.
// - reset in S1 -> PEND0, with the same counting rule.
// - SETTLE_CYC=0: S0<->S1 directly on the sampling edge, with no pending state.
// - set in S1 or PEND1, or reset in S0 or PEND0: no state change and no viol (idempotent).
// - set and reset in the same cycle: viol=1; state and counter unchanged.
// - Opposite pulse during PEND: target flips, counter reloads, viol=1 (last pulse wins).
// - state output: 1 in S1 or PEND0, 0 in S0 or PEND1.
// - While pending, state shows the old value; it updates in the cycle the FSM enters S0/S1.
// - rd: out=state (pre-edge value) on the next cycle. Latency 1.
// - rd in PEND0/PEND1: out shows the old value and viol=1.
// - rd in the same cycle as set/reset: out uses the pre-edge state.
// - rd on consecutive cycles: each read produces its own pulse.
// - DESTRUCTIVE=1: rd in S1 emits out=1 and the cell moves to S0 immediately (no settle).
// - DESTRUCTIVE=1, rd and set together in S1: out=1, then the cell stays in S1 (set wins).
// - DESTRUCTIVE=1, rd and reset together in S1: out=1, then S0, with no viol.
// - Channels are fully independent; no cross-channel interaction.
// - viol: OR of all violation causes for that channel, asserted one cycle after the cause.
// - rst_n asserted mid-settle: the pending state is discarded and the cell returns to S0.
// CONFIGURATION
// - NDRO_BANK_VIOL_CNT_EN defined:
//   - port viol_cnt is present.
//   - Increments by 1 on every cycle where |viol is high.
//   - Saturates at 2^CNT_W-1; cleared only by rst_n.
// - NDRO_BANK_VIOL_CNT_EN undefined:
//   - viol_cnt port and counter logic are absent.
//   - viol behaviour is identical in both builds.
// TESTING
// - Default params: set[0] @c1; rd[0] @c2 -> out[0]=0, viol[0]=1; rd[0] @c4 -> out[0]=1, viol[0]=0.
// - set[1]&reset[1] same cycle from S0 -> viol[1]=1, state[1] stays 0; viol_cnt=1 (macro build).
// - Stored 1, rd[2] three consecutive cycles -> out[2]=1 three times, state[2] remains 1.
// - DESTRUCTIVE=1: stored 1, rd[3] -> out[3]=1; second rd[3] next cycle -> out[3]=0, state[3]=0.
// - set[0] then reset[0] one cycle later (SETTLE_CYC=2) -> viol[0]=1, final state[0]=0 after 2 cycles.
// - rst_n low during PEND1 -> all outputs 0 asynchronously; after release, rd -> out=0.

Source files
------------

// File: rtl/mitll_ndro_bank.sv
// Clocked behavioural bank of RSFQ NDRO cells with a settling window, violation flags and optional DRO read.
// Define NDRO_BANK_VIOL_CNT_EN to add the saturating viol_cnt output.
module mitll_ndro_bank #(
    parameter int CHANNELS    = 4,
    parameter int SETTLE_CYC  = 2,
    parameter bit DESTRUCTIVE = 0
`ifdef NDRO_BANK_VIOL_CNT_EN
    ,
    parameter int CNT_W       = 8
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] set,
    input  logic [CHANNELS-1:0] reset,
    input  logic [CHANNELS-1:0] rd,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] state,
    output logic [CHANNELS-1:0] viol
`ifdef NDRO_BANK_VIOL_CNT_EN
    ,
    output logic [CNT_W-1:0]    viol_cnt
`endif
);

    typedef enum logic [1:0] {S0, S1, PEND1, PEND0} cell_t;

    localparam bit         DIRECT = (SETTLE_CYC == 0);
    localparam logic [3:0] RELOAD = DIRECT ? 4'd0 : 4'(SETTLE_CYC - 1);

    cell_t               cur     [CHANNELS];
    cell_t               nxt     [CHANNELS];
    logic [3:0]          cnt     [CHANNELS];
    logic [3:0]          cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] viol_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cur[c] <= S0;
                cnt[c] <= '0;
            end
            out  <= '0;
            viol <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                cur[c] <= nxt[c];
                cnt[c] <= cnt_nxt[c];
            end
            out  <= rd & state;
            viol <= viol_nxt;
        end
    end

    // A simultaneous set+reset freezes the cell; an opposite pulse while pending retargets and restarts the window.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            nxt[c]      = cur[c];
            cnt_nxt[c]  = cnt[c];
            viol_nxt[c] = rd[c] && ((cur[c] == PEND1) || (cur[c] == PEND0));
            if (set[c] && reset[c]) begin
                viol_nxt[c] = 1'b1;
            end else begin
                case (cur[c])
                    S0: begin
                        if (set[c]) begin
                            nxt[c]     = DIRECT ? S1 : PEND1;
                            cnt_nxt[c] = RELOAD;
                        end
                    end
                    S1: begin
                        if (DESTRUCTIVE && rd[c] && !set[c]) begin
                            nxt[c] = S0;
                        end else if (reset[c]) begin
                            nxt[c]     = DIRECT ? S0 : PEND0;
                            cnt_nxt[c] = RELOAD;
                        end
                    end
                    PEND1: begin
                        if (reset[c]) begin
                            nxt[c]      = PEND0;
                            cnt_nxt[c]  = RELOAD;
                            viol_nxt[c] = 1'b1;
                        end else if (cnt[c] == 4'd0) begin
                            nxt[c] = S1;
                        end else begin
                            cnt_nxt[c] = cnt[c] - 4'd1;
                        end
                    end
                    PEND0: begin
                        if (set[c]) begin
                            nxt[c]      = PEND1;
                            cnt_nxt[c]  = RELOAD;
                            viol_nxt[c] = 1'b1;
                        end else if (cnt[c] == 4'd0) begin
                            nxt[c] = S0;
                        end else begin
                            cnt_nxt[c] = cnt[c] - 4'd1;
                        end
                    end
                    default: nxt[c] = S0;
                endcase
            end
        end
    end

    // While pending the readable value is still the one being replaced.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            state[c] = (cur[c] == S1) || (cur[c] == PEND0);
        end
    end

`ifdef NDRO_BANK_VIOL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_cnt <= '0;
        end else if ((|viol) && (viol_cnt != '1)) begin
            viol_cnt <= viol_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mitll_ndro_bank.sv
// Self-checking bench for mitll_ndro_bank: a non-destructive and a destructive bank share one stimulus stream
// and are compared every cycle against a cell model kept as (target value, pending flag, edges remaining).
module tb_mitll_ndro_bank;

    localparam int CH = 4;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] set_i, reset_i, rd_i;
    logic [CH-1:0] out_a, state_a, viol_a;
    logic [CH-1:0] out_b, state_b, viol_b;
`ifdef NDRO_BANK_VIOL_CNT_EN
    logic [7:0]    vcnt_a, vcnt_b;
`endif

    int checks = 0;
    int fails  = 0;

    bit            m_tgt  [2][CH];
    bit            m_pend [2][CH];
    int            m_rem  [2][CH];
    logic [CH-1:0] m_out  [2];
    logic [CH-1:0] m_viol [2];
    int            m_vcnt;

    always #5 clk = ~clk;

    mitll_ndro_bank #(.CHANNELS(CH), .SETTLE_CYC(SC), .DESTRUCTIVE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .set(set_i), .reset(reset_i), .rd(rd_i),
        .out(out_a), .state(state_a), .viol(viol_a)
`ifdef NDRO_BANK_VIOL_CNT_EN
        , .viol_cnt(vcnt_a)
`endif
    );

    mitll_ndro_bank #(.CHANNELS(CH), .SETTLE_CYC(SC), .DESTRUCTIVE(1'b1)) dut_d (
        .clk(clk), .rst_n(rst_n), .set(set_i), .reset(reset_i), .rd(rd_i),
        .out(out_b), .state(state_b), .viol(viol_b)
`ifdef NDRO_BANK_VIOL_CNT_EN
        , .viol_cnt(vcnt_b)
`endif
    );

    function automatic logic [CH-1:0] m_state(input int k);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = m_pend[k][c] ? !m_tgt[k][c] : m_tgt[k][c];
        return r;
    endfunction

    function automatic logic [6*CH-1:0] observed();
        return {out_a, state_a, viol_a, out_b, state_b, viol_b};
    endfunction

    function automatic logic [6*CH-1:0] expected();
        return {m_out[0], m_state(0), m_viol[0], m_out[1], m_state(1), m_viol[1]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < CH; c++) begin
                m_tgt[k][c]  = 1'b0;
                m_pend[k][c] = 1'b0;
                m_rem[k][c]  = 0;
            end
            m_out[k]  = '0;
            m_viol[k] = '0;
        end
        m_vcnt = 0;
    endtask

    task automatic model_start(input int k, input int c, input bit v);
        m_tgt[k][c]  = v;
        m_pend[k][c] = (SC != 0);
        m_rem[k][c]  = SC;
    endtask

    // One rising edge of the cell rules for both banks (k=1 is the destructive one).
    task automatic model_edge(input logic [CH-1:0] s, input logic [CH-1:0] r, input logic [CH-1:0] d);
        bit vis, v;
        if (m_viol[0] != '0 && m_vcnt < 255) m_vcnt++;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < CH; c++) begin
                vis = m_pend[k][c] ? !m_tgt[k][c] : m_tgt[k][c];
                m_out[k][c] = d[c] && vis;
                v = d[c] && m_pend[k][c];
                if (s[c] && r[c]) begin
                    v = 1'b1;
                end else if (m_pend[k][c]) begin
                    if ((s[c] && !m_tgt[k][c]) || (r[c] && m_tgt[k][c])) begin
                        m_tgt[k][c] = s[c];
                        m_rem[k][c] = SC;
                        v = 1'b1;
                    end else begin
                        m_rem[k][c]--;
                        if (m_rem[k][c] == 0) m_pend[k][c] = 1'b0;
                    end
                end else if (k == 1 && d[c] && m_tgt[k][c] && !s[c]) begin
                    m_tgt[k][c] = 1'b0;
                end else if (s[c] && !m_tgt[k][c]) begin
                    model_start(k, c, 1'b1);
                end else if (r[c] && m_tgt[k][c]) begin
                    model_start(k, c, 1'b0);
                end
                m_viol[k][c] = v;
            end
        end
    endtask

    // Called 1 time unit after an edge; leaves the bench 1 time unit after the next edge.
    task automatic step(input logic [CH-1:0] s, input logic [CH-1:0] r, input logic [CH-1:0] d);
        set_i   = s;
        reset_i = r;
        rd_i    = d;
        @(posedge clk);
        model_edge(s, r, d);
        #1;
        set_i   = '0;
        reset_i = '0;
        rd_i    = '0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        set_i   = '0;
        reset_i = '0;
        rd_i    = '0;
        model_reset();
        #12;
        checks++;
        if (observed() !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs got=%h want=0", observed());
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_edge('0, '0, '0);
    endtask

    task automatic test_settle_read();
        step(4'h1, 4'h0, 4'h0);
        step(4'h0, 4'h0, 4'h1);
        checks++;
        if ({out_a[0], viol_a[0]} !== 2'b01) begin
            fails++;
            $display("[TB] FAIL settle_read_pending got out/viol=%b want=01", {out_a[0], viol_a[0]});
        end
        step(4'h0, 4'h0, 4'h0);
        step(4'h0, 4'h0, 4'h1);
        checks++;
        if ({out_a[0], viol_a[0]} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL settle_read_settled got out/viol=%b want=10", {out_a[0], viol_a[0]});
        end
        checks++;
        if (observed() !== expected()) begin
            fails++;
            $display("[TB] FAIL settle_read_model got=%h want=%h", observed(), expected());
        end
    endtask

    task automatic test_conflict();
        step(4'h2, 4'h2, 4'h0);
        checks++;
        if ({viol_a[1], state_a[1]} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL conflict got viol/state=%b want=10", {viol_a[1], state_a[1]});
        end
        step(4'h0, 4'h0, 4'h0);
        checks++;
        if (observed() !== expected()) begin
            fails++;
            $display("[TB] FAIL conflict_model got=%h want=%h", observed(), expected());
        end
`ifdef NDRO_BANK_VIOL_CNT_EN
        checks++;
        if (int'(vcnt_a) !== m_vcnt) begin
            fails++;
            $display("[TB] FAIL viol_cnt got=%0d want=%0d", vcnt_a, m_vcnt);
        end
`endif
    endtask

    task automatic test_back_to_back_reads();
        step(4'h4, 4'h0, 4'h0);
        step(4'h0, 4'h0, 4'h0);
        step(4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step(4'h0, 4'h0, 4'h4);
            checks++;
            if ({out_a[2], state_a[2]} !== 2'b11) begin
                fails++;
                $display("[TB] FAIL back_to_back_read%0d got out/state=%b want=11", i, {out_a[2], state_a[2]});
            end
            checks++;
            if (observed() !== expected()) begin
                fails++;
                $display("[TB] FAIL back_to_back_model%0d got=%h want=%h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_destructive();
        step(4'h8, 4'h0, 4'h0);
        step(4'h0, 4'h0, 4'h0);
        step(4'h0, 4'h0, 4'h0);
        step(4'h0, 4'h0, 4'h8);
        checks++;
        if ({out_b[3], state_b[3], out_a[3], state_a[3]} !== 4'b1011) begin
            fails++;
            $display("[TB] FAIL dro_first_read got=%b want=1011",
                     {out_b[3], state_b[3], out_a[3], state_a[3]});
        end
        step(4'h0, 4'h0, 4'h8);
        checks++;
        if ({out_b[3], state_b[3]} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL dro_second_read got out/state=%b want=00", {out_b[3], state_b[3]});
        end
    endtask

    task automatic test_flip();
        step(4'h0, 4'h1, 4'h0);
        step(4'h0, 4'h0, 4'h0);
        step(4'h0, 4'h0, 4'h0);
        step(4'h1, 4'h0, 4'h0);
        step(4'h0, 4'h1, 4'h0);
        checks++;
        if (viol_a[0] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL flip_viol got=%b want=1", viol_a[0]);
        end
        step(4'h0, 4'h0, 4'h0);
        step(4'h0, 4'h0, 4'h0);
        checks++;
        if (state_a[0] !== 1'b0 || observed() !== expected()) begin
            fails++;
            $display("[TB] FAIL flip_final got=%h want=%h", observed(), expected());
        end
    endtask

    task automatic test_async_reset();
        step(4'h2, 4'h0, 4'h0);
        step(4'h0, 4'h0, 4'h0);
        step(4'h0, 4'h0, 4'h0);
        step(4'h1, 4'h0, 4'h0);
        checks++;
        if (state_a[1] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL pre_reset_state got=%b want=1", state_a[1]);
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (observed() !== '0) begin
            fails++;
            $display("[TB] FAIL async_reset got=%h want=0", observed());
        end
        #2;
        rst_n = 1'b1;
        step(4'h0, 4'h0, 4'h0);
        step(4'h0, 4'h0, 4'h1);
        checks++;
        if (out_a[0] !== 1'b0 || observed() !== expected()) begin
            fails++;
            $display("[TB] FAIL post_reset_read got=%h want=%h", observed(), expected());
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] s, r, d;
        for (int i = 0; i < 300; i++) begin
            s = CH'($urandom & $urandom);
            r = CH'($urandom & $urandom);
            d = CH'($urandom);
            step(s, r, d);
            checks++;
            if (observed() !== expected()) begin
                fails++;
                $display("[TB] FAIL random_cycle%0d got=%h want=%h", i, observed(), expected());
            end
        end
`ifdef NDRO_BANK_VIOL_CNT_EN
        checks++;
        if (int'(vcnt_a) !== m_vcnt) begin
            fails++;
            $display("[TB] FAIL random_viol_cnt got=%0d want=%0d", vcnt_a, m_vcnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_settle_read();
        test_conflict();
        test_back_to_back_reads();
        test_destructive();
        test_flip();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
